// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake bundle between the multicycle controller and the shared
// instruction/data memory port.
//   mem_req      : access request, held until an edge samples mem_ready=1
//   mem_we       : write qualifier for mem_req
//   mem_addr_sel : 0 = PC, 1 = ALU register
//   mem_ready    : memory completes the current access at this edge
// Modports: master = controller side, slave = memory side.
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a multicycle RV32I datapath with a req/ready memory port.
// Sequences PC, CurrentPC, IR, data register and ALU register, and drives all
// enables and mux selects. Optional SYSTEM halt is built when the macro
// MULTICYCLE_ECALL_HALT_EN is defined; otherwise opcode 1110011 is illegal.
// Ports:
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   memBus             : memory handshake (master modport)
//   opcode             : IR[6:0]
//   branch_taken       : ALU compare result, valid in BRANCH
//   ir_we .. reg_we    : register write enables
//   reg_src, alu_a_sel, alu_b_sel, alu_op, pc_src : datapath selects
//   fault, halted      : sticky status, cleared only by reset
//   state              : current state code for debug
// Parameters: MEM_TIMEOUT wait cycles before bus fault (0 disables);
//             TIMER_W wait-counter width, 2**TIMER_W must exceed MEM_TIMEOUT.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TIMER_W     = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  multicycle_control_fsm_if.master        memBus,
  input  logic [6:0]                      opcode,
  input  logic                            branch_taken,
  output logic                            ir_we,
  output logic                            cur_pc_we,
  output logic                            pc_we,
  output logic                            dr_we,
  output logic                            reg_we,
  output logic [1:0]                      reg_src,
  output logic [1:0]                      alu_a_sel,
  output logic [1:0]                      alu_b_sel,
  output logic [1:0]                      alu_op,
  output logic                            pc_src,
  output logic                            fault,
  output logic                            halted,
  output logic [3:0]                      state
);

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StExecR    = 4'd3,
    StExecI    = 4'd4,
    StAddr     = 4'd5,
    StMemRd    = 4'd6,
    StMemWr    = 4'd7,
    StWbMem    = 4'd8,
    StWbAlu    = 4'd9,
    StBranch   = 4'd10,
    StJal      = 4'd11,
    StJalrAddr = 4'd12,
    StJalrWb   = 4'd13,
    StFault    = 4'd14,
    StHalt     = 4'd15
  } state_e;

  // EXEC_I flavour, latched in DECODE so EXEC_I outputs depend on state only.
  typedef enum logic [1:0] {
    ExecFunct = 2'd0,
    ExecLui   = 2'd1,
    ExecAuipc = 2'd2
  } exec_kind_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
`ifdef MULTICYCLE_ECALL_HALT_EN
  localparam logic [6:0] OpSystem = 7'b1110011;
`endif

  localparam logic [TIMER_W-1:0] TimeoutCnt = TIMER_W'(MEM_TIMEOUT);

  state_e             stateQ, stateD;
  exec_kind_e         execKindQ, execKindD;
  logic [TIMER_W-1:0] waitCntQ, waitCntD;
  logic               reqState;
  logic               timedOut;

  assign reqState = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);
  assign timedOut = (MEM_TIMEOUT != 0) && (waitCntQ == TimeoutCnt);
  assign state    = stateQ;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ    <= StReset;
      execKindQ <= ExecFunct;
      waitCntQ  <= '0;
    end else begin
      stateQ    <= stateD;
      execKindQ <= execKindD;
      waitCntQ  <= waitCntD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    execKindD = execKindQ;
    case (stateQ)
      StReset:  stateD = StFetch;
      StFetch: begin
        // A ready on the timeout edge takes priority over the fault.
        if (memBus.mem_ready)  stateD = StDecode;
        else if (timedOut)     stateD = StFault;
      end
      StDecode: begin
        execKindD = ExecFunct;
        case (opcode)
          OpReg:            stateD = StExecR;
          OpImm:            stateD = StExecI;
          OpLoad, OpStore:  stateD = StAddr;
          OpBranch:         stateD = StBranch;
          OpJal:            stateD = StJal;
          OpJalr:           stateD = StJalrAddr;
          OpLui: begin
            stateD    = StExecI;
            execKindD = ExecLui;
          end
          OpAuipc: begin
            stateD    = StExecI;
            execKindD = ExecAuipc;
          end
`ifdef MULTICYCLE_ECALL_HALT_EN
          OpSystem:         stateD = StHalt;
`endif
          default:          stateD = StFault;
        endcase
      end
      StExecR, StExecI: stateD = StWbAlu;
      StAddr:   stateD = (opcode == OpStore) ? StMemWr : StMemRd;
      StMemRd: begin
        if (memBus.mem_ready)  stateD = StWbMem;
        else if (timedOut)     stateD = StFault;
      end
      StMemWr: begin
        if (memBus.mem_ready)  stateD = StFetch;
        else if (timedOut)     stateD = StFault;
      end
      StWbMem, StWbAlu, StBranch, StJal, StJalrWb: stateD = StFetch;
      StJalrAddr: stateD = StJalrWb;
      default:  stateD = stateQ;
    endcase

    // Clears on any state change (covers entry to every request state,
    // including back-to-back MEM_WR -> FETCH); saturates rather than wraps.
    waitCntD = waitCntQ;
    if (stateD != stateQ) begin
      waitCntD = '0;
    end else if (reqState && !memBus.mem_ready && (waitCntQ != '1)) begin
      waitCntD = waitCntQ + 1'b1;
    end
  end

  always_comb begin
    memBus.mem_req      = 1'b0;
    memBus.mem_we       = 1'b0;
    memBus.mem_addr_sel = 1'b0;
    ir_we               = 1'b0;
    cur_pc_we           = 1'b0;
    pc_we               = 1'b0;
    dr_we               = 1'b0;
    reg_we              = 1'b0;
    reg_src             = 2'd0;
    alu_a_sel           = 2'd0;
    alu_b_sel           = 2'd0;
    alu_op              = 2'd0;
    pc_src              = 1'b0;
    fault               = 1'b0;
    halted              = 1'b0;
    case (stateQ)
      StFetch: begin
        memBus.mem_req = 1'b1;
        alu_a_sel      = 2'd1;
        alu_b_sel      = 2'd1;
        // Enables qualified by ready so PC advances exactly once per fetch.
        ir_we          = memBus.mem_ready;
        cur_pc_we      = memBus.mem_ready;
        pc_we          = memBus.mem_ready;
      end
      StDecode: begin
        alu_a_sel = 2'd0;
        alu_b_sel = 2'd2;
      end
      StExecR: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 2'd0;
        alu_op    = 2'd2;
      end
      StExecI: begin
        alu_b_sel = 2'd2;
        case (execKindQ)
          ExecLui:   alu_a_sel = 2'd3;
          ExecAuipc: alu_a_sel = 2'd0;
          default: begin
            alu_a_sel = 2'd2;
            alu_op    = 2'd2;
          end
        endcase
      end
      StAddr, StJalrAddr: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 2'd2;
      end
      StMemRd: begin
        memBus.mem_req      = 1'b1;
        memBus.mem_addr_sel = 1'b1;
        dr_we               = memBus.mem_ready;
      end
      StMemWr: begin
        memBus.mem_req      = 1'b1;
        memBus.mem_we       = 1'b1;
        memBus.mem_addr_sel = 1'b1;
      end
      StWbMem: begin
        reg_we  = 1'b1;
        reg_src = 2'd2;
      end
      StWbAlu:  reg_we = 1'b1;
      StBranch: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 2'd0;
        alu_op    = 2'd1;
        pc_src    = 1'b1;
        pc_we     = branch_taken;
      end
      StJal, StJalrWb: begin
        reg_we  = 1'b1;
        reg_src = 2'd1;
        pc_we   = 1'b1;
        pc_src  = 1'b1;
      end
      StFault:  fault = 1'b1;
`ifdef MULTICYCLE_ECALL_HALT_EN
      StHalt:   halted = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       branchTaken = 1'b0;
  logic       irWe, curPcWe, pcWe, drWe, regWe, pcSrc, fault, halted;
  logic [1:0] regSrc, aluASel, aluBSel, aluOp;
  logic [3:0] state;

  multicycle_control_fsm_if memBus ();

  multicycle_control_fsm #(
    .MEM_TIMEOUT(15),
    .TIMER_W    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .memBus      (memBus),
    .opcode      (opcode),
    .branch_taken(branchTaken),
    .ir_we       (irWe),
    .cur_pc_we   (curPcWe),
    .pc_we       (pcWe),
    .dr_we       (drWe),
    .reg_we      (regWe),
    .reg_src     (regSrc),
    .alu_a_sel   (aluASel),
    .alu_b_sel   (aluBSel),
    .alu_op      (aluOp),
    .pc_src      (pcSrc),
    .fault       (fault),
    .halted      (halted),
    .state       (state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Leaves the bench at a falling edge with the FSM freshly in FETCH.
  task automatic doReset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  function automatic int allOutputs();
    return int'(irWe) + int'(curPcWe) + int'(pcWe) + int'(drWe) + int'(regWe) + int'(pcSrc)
         + int'(fault) + int'(halted) + int'(regSrc) + int'(aluASel) + int'(aluBSel)
         + int'(aluOp) + int'(memBus.mem_req) + int'(memBus.mem_we)
         + int'(memBus.mem_addr_sel);
  endfunction

  typedef struct {
    logic [6:0]      op;
    logic            bt;
    int              len;
    logic [0:4][3:0] seq;
    int              regWes;
    int              pcWes;
    int              drWes;
    int              weCyc;
    int              aluA;    // selects expected in the third cycle
    int              aluB;
    int              aluOpE;
    int              pcSrcE;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int total, rdCyc, drPulses, fetchCyc;
    int regWes, pcWes, drWes, weCyc;

    vecs[0] = '{7'b0110011, 1'b0, 4, {4'd1, 4'd2, 4'd3, 4'd9, 4'd0}, 1, 1, 0, 0, 2, 0, 2, 0};
    vecs[1] = '{7'b0010011, 1'b0, 4, {4'd1, 4'd2, 4'd4, 4'd9, 4'd0}, 1, 1, 0, 0, 2, 2, 2, 0};
    vecs[2] = '{7'b0110111, 1'b0, 4, {4'd1, 4'd2, 4'd4, 4'd9, 4'd0}, 1, 1, 0, 0, 3, 2, 0, 0};
    vecs[3] = '{7'b0010111, 1'b0, 4, {4'd1, 4'd2, 4'd4, 4'd9, 4'd0}, 1, 1, 0, 0, 0, 2, 0, 0};
    vecs[4] = '{7'b0000011, 1'b0, 5, {4'd1, 4'd2, 4'd5, 4'd6, 4'd8}, 1, 1, 1, 0, 2, 2, 0, 0};
    vecs[5] = '{7'b0100011, 1'b0, 4, {4'd1, 4'd2, 4'd5, 4'd7, 4'd0}, 0, 1, 0, 1, 2, 2, 0, 0};
    vecs[6] = '{7'b1100011, 1'b0, 3, {4'd1, 4'd2, 4'd10, 4'd0, 4'd0}, 0, 1, 0, 0, 2, 0, 1, 1};
    vecs[7] = '{7'b1100011, 1'b1, 3, {4'd1, 4'd2, 4'd10, 4'd0, 4'd0}, 0, 2, 0, 0, 2, 0, 1, 1};
    vecs[8] = '{7'b1101111, 1'b0, 3, {4'd1, 4'd2, 4'd11, 4'd0, 4'd0}, 1, 2, 0, 0, 0, 0, 0, 1};
    vecs[9] = '{7'b1100111, 1'b0, 4, {4'd1, 4'd2, 4'd12, 4'd13, 4'd0}, 1, 2, 0, 0, 2, 2, 0, 0};

    // Reset state and first request after release.
    memBus.mem_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("reset state", int'(state), 0);
    check("reset outputs", allOutputs(), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("no req before first edge", int'(memBus.mem_req), 0);
    @(negedge clock);
    #1;
    check("fetch after release", int'(state), 1);
    check("req after first edge", int'(memBus.mem_req), 1);

    // Zero-wait instruction table.
    doReset();
    memBus.mem_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      opcode      = vecs[v].op;
      branchTaken = vecs[v].bt;
      regWes = 0; pcWes = 0; drWes = 0; weCyc = 0;
      for (int c = 0; c < vecs[v].len; c++) begin
        #1;
        check($sformatf("v%0d state c%0d", v, c), int'(state), int'(vecs[v].seq[c]));
        if (c == 2) begin
          check($sformatf("v%0d alu_a", v), int'(aluASel), vecs[v].aluA);
          check($sformatf("v%0d alu_b", v), int'(aluBSel), vecs[v].aluB);
          check($sformatf("v%0d alu_op", v), int'(aluOp), vecs[v].aluOpE);
          check($sformatf("v%0d pc_src", v), int'(pcSrc), vecs[v].pcSrcE);
        end
        regWes += int'(regWe);
        pcWes  += int'(pcWe);
        drWes  += int'(drWe);
        weCyc  += int'(memBus.mem_we);
        @(negedge clock);
      end
      check($sformatf("v%0d reg_we count", v), regWes, vecs[v].regWes);
      check($sformatf("v%0d pc_we count", v), pcWes, vecs[v].pcWes);
      check($sformatf("v%0d dr_we count", v), drWes, vecs[v].drWes);
      check($sformatf("v%0d mem_we cycles", v), weCyc, vecs[v].weCyc);
    end
    #1;
    check("back in fetch after table", int'(state), 1);

    // Load with three wait cycles on MEM_RD.
    doReset();
    opcode = 7'b0000011;
    memBus.mem_ready = 1'b1;
    total = 0; rdCyc = 0; drPulses = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (i > 0 && state == 4'd1) break;
      total++;
      if (state == 4'd6) begin
        rdCyc++;
        memBus.mem_ready = (rdCyc == 4);
        #1;
        check($sformatf("load req held c%0d", rdCyc), int'(memBus.mem_req), 1);
        drPulses += int'(drWe);
      end else begin
        memBus.mem_ready = 1'b1;
      end
      @(negedge clock);
    end
    check("load total cycles", total, 8);
    check("load MEM_RD cycles", rdCyc, 4);
    check("load dr_we pulses", drPulses, 1);

    // Fetch timeout: 16 cycles in FETCH then sticky FAULT.
    doReset();
    memBus.mem_ready = 1'b0;
    fetchCyc = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (state != 4'd1) break;
      fetchCyc++;
      @(negedge clock);
    end
    check("timeout fetch cycles", fetchCyc, 16);
    check("timeout state", int'(state), 14);
    check("timeout fault", int'(fault), 1);
    memBus.mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("fault sticky state", int'(state), 14);
    check("fault sticky flag", int'(fault), 1);
    check("fault no req", int'(memBus.mem_req), 0);

    // Ready on the timeout edge wins.
    doReset();
    opcode = 7'b0110011;
    memBus.mem_ready = 1'b0;
    repeat (15) @(negedge clock);
    #1;
    check("late ready still fetch", int'(state), 1);
    memBus.mem_ready = 1'b1;
    @(negedge clock);
    #1;
    check("late ready decode", int'(state), 2);
    check("late ready no fault", int'(fault), 0);

    // SYSTEM opcode.
    doReset();
    opcode = 7'b1110011;
    memBus.mem_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
`ifdef MULTICYCLE_ECALL_HALT_EN
    check("ecall state", int'(state), 15);
    check("ecall halted", int'(halted), 1);
    check("ecall fault", int'(fault), 0);
`else
    check("ecall state", int'(state), 14);
    check("ecall halted", int'(halted), 0);
    check("ecall fault", int'(fault), 1);
`endif

    // Reset asserted mid-MEM_WR drops the request in the same cycle.
    doReset();
    opcode = 7'b0100011;
    memBus.mem_ready = 1'b1;
    @(negedge clock);
    memBus.mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("store wait state", int'(state), 7);
    check("store req", int'(memBus.mem_req), 1);
    check("store we", int'(memBus.mem_we), 1);
    check("store addr sel", int'(memBus.mem_addr_sel), 1);
    #1 reset = 1'b1;
    #1;
    check("async reset state", int'(state), 0);
    check("async reset req", int'(memBus.mem_req), 0);
    check("async reset we", int'(memBus.mem_we), 0);
    @(negedge clock);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
